// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path.
//   state_t      : FSM state encoding (also exported on the debug port)
//   OP_* / FN_*  : supported opcode and R-type funct encodings
//   ALU_*        : alu_ctrl operation codes
//   PC_* / SRCB_*: pc_src and alu_src_b mux select codes
//   opcode_known : true for any opcode the controller can execute
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    function automatic logic opcode_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: opcode_known = 1'b1;
            default:                                      opcode_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder.
//   funct         : instr[5:0]
//   alu_ctrl      : ALU operation for the funct (add when unlisted)
//   funct_illegal : funct is not one of the supported R-type operations
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_illegal
);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset CPU.
// Sequences IF/ID/EX/MEM/WB, counts retired instructions and traps
// illegal encodings.
//   clk, reset           : clock, synchronous active-high reset
//   opcode, funct, zero  : IR fields and ALU zero flag
//   pc_en..alu_ctrl      : datapath enables and mux selects
//   instr_done, illegal  : retire / illegal-encoding pulses
//   halted, state        : trap status and debug state
//   instr_cnt            : retired-instruction counter (wraps)
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             instr_done,
    output logic             illegal,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0] dec_alu_ctrl;
    logic       funct_illegal;
    logic       instr_illegal;

    // Raw strobes before reset gating.
    logic pc_en_r, mem_read_r, mem_write_r, ir_write_r, reg_write_r;
    logic done_r, illegal_r;

    alu_decoder u_alu_decoder (
        .funct         (funct),
        .alu_ctrl      (dec_alu_ctrl),
        .funct_illegal (funct_illegal)
    );

    assign instr_illegal = !opcode_known(opcode) ||
                           ((opcode == OP_RTYPE) && funct_illegal);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (done_r)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_en_r     = 1'b0;
        mem_read_r  = 1'b0;
        mem_write_r = 1'b0;
        ir_write_r  = 1'b0;
        reg_write_r = 1'b0;
        done_r      = 1'b0;
        illegal_r   = 1'b0;
        pc_src      = PC_ALU;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_ctrl    = ALU_ADD;

        case (state_q)
            S_IF: begin
                // Fetch and PC+4 in parallel; opcode is not yet valid here.
                mem_read_r = 1'b1;
                ir_write_r = 1'b1;
                alu_src_b  = SRCB_4;
                pc_en_r    = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH;
                if (opcode == OP_J) begin
                    pc_src  = PC_JUMP;
                    pc_en_r = 1'b1;
                    done_r  = 1'b1;
                    state_d = S_IF;
                end else if (instr_illegal) begin
                    illegal_r = 1'b1;
                    state_d   = (ILLEGAL_TRAP != 0) ? S_HALT : S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_ctrl = dec_alu_ctrl;
                        state_d  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_MEM;
                    end
                    OP_ADDI: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_WB;
                    end
                    OP_BEQ: begin
                        // Branch retires here whether or not it is taken.
                        alu_ctrl = ALU_SUB;
                        pc_src   = PC_ALUOUT;
                        pc_en_r  = zero;
                        done_r   = 1'b1;
                        state_d  = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                iord = 1'b1;
                case (opcode)
                    OP_LW: begin
                        mem_read_r = 1'b1;
                        state_d    = S_WB;
                    end
                    OP_SW: begin
                        mem_write_r = 1'b1;
                        done_r      = 1'b1;
                        state_d     = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_WB: begin
                reg_write_r = 1'b1;
                done_r      = 1'b1;
                state_d     = S_IF;
                case (opcode)
                    OP_RTYPE: reg_dst    = 1'b1;
                    OP_LW:    mem_to_reg = 1'b1;
                    default:  ;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Strobes are suppressed combinationally so nothing reaches memory or
    // the register file in the cycle reset is raised.
    assign pc_en      = pc_en_r     & ~reset;
    assign mem_read   = mem_read_r  & ~reset;
    assign mem_write  = mem_write_r & ~reset;
    assign ir_write   = ir_write_r  & ~reset;
    assign reg_write  = reg_write_r & ~reset;
    assign instr_done = done_r      & ~reset;
    assign illegal    = illegal_r   & ~reset;

    assign halted    = (state_q == S_HALT);
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut0: default parameters (skip on illegal)
    logic        reset, zero;
    logic [5:0]  opcode, funct;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, instr_done, illegal, halted;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_ctrl, state;
    logic [31:0] instr_cnt;

    // dut1: trap on illegal
    logic        reset1;
    logic [5:0]  opcode1;
    logic        pc_en1, iord1, mem_read1, mem_write1, ir_write1, reg_write1;
    logic        reg_dst1, mem_to_reg1, alu_src_a1, instr_done1, illegal1, halted1;
    logic [1:0]  pc_src1, alu_src_b1;
    logic [2:0]  alu_ctrl1, state1;
    logic [31:0] instr_cnt1;

    // dut2: 4-bit counter, fed only J
    logic        reset2;
    logic        pc_en2, iord2, mem_read2, mem_write2, ir_write2, reg_write2;
    logic        reg_dst2, mem_to_reg2, alu_src_a2, instr_done2, illegal2, halted2;
    logic [1:0]  pc_src2, alu_src_b2;
    logic [2:0]  alu_ctrl2, state2;
    logic [3:0]  instr_cnt2;

    multicycle_ctrl #(.CNT_W(32), .ILLEGAL_TRAP(0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .instr_done(instr_done),
        .illegal(illegal), .halted(halted), .state(state), .instr_cnt(instr_cnt)
    );

    multicycle_ctrl #(.CNT_W(32), .ILLEGAL_TRAP(1)) dut_trap (
        .clk(clk), .reset(reset1), .opcode(opcode1), .funct(6'h20), .zero(1'b0),
        .pc_en(pc_en1), .pc_src(pc_src1), .iord(iord1), .mem_read(mem_read1),
        .mem_write(mem_write1), .ir_write(ir_write1), .reg_write(reg_write1),
        .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .alu_src_a(alu_src_a1),
        .alu_src_b(alu_src_b1), .alu_ctrl(alu_ctrl1), .instr_done(instr_done1),
        .illegal(illegal1), .halted(halted1), .state(state1), .instr_cnt(instr_cnt1)
    );

    multicycle_ctrl #(.CNT_W(4), .ILLEGAL_TRAP(0)) dut_wrap (
        .clk(clk), .reset(reset2), .opcode(6'h02), .funct(6'h00), .zero(1'b0),
        .pc_en(pc_en2), .pc_src(pc_src2), .iord(iord2), .mem_read(mem_read2),
        .mem_write(mem_write2), .ir_write(ir_write2), .reg_write(reg_write2),
        .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_ctrl(alu_ctrl2), .instr_done(instr_done2),
        .illegal(illegal2), .halted(halted2), .state(state2), .instr_cnt(instr_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [5:0] fn_tab [4];
    logic [2:0] alu_tab [4];

    initial begin
        fn_tab  = '{6'h22, 6'h24, 6'h25, 6'h2A};
        alu_tab = '{3'b110, 3'b000, 3'b001, 3'b111};

        reset = 1'b1; reset1 = 1'b1; reset2 = 1'b1;
        opcode = 6'h00; funct = 6'h20; zero = 1'b0; opcode1 = 6'h3F;

        // Reset held 3 cycles
        repeat (3) tick();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_strobes", {27'd0, pc_en, mem_read, ir_write, reg_write, mem_write}, 32'd0);

        // R-type add
        reset = 1'b0;
        #1;
        chk("if_strobes", {28'd0, pc_en, mem_read, ir_write, iord}, 32'b1110);
        chk("if_srcb", {30'd0, alu_src_b}, 32'd1);
        tick();
        chk("add_id_state", {29'd0, state}, 32'd1);
        chk("add_id_srcb", {30'd0, alu_src_b}, 32'd3);
        chk("add_id_regw", {31'd0, reg_write}, 32'd0);
        tick();
        chk("add_ex_state", {29'd0, state}, 32'd2);
        chk("add_ex_alu", {28'd0, alu_src_a, alu_ctrl}, 32'b1010);
        chk("add_ex_regw", {31'd0, reg_write}, 32'd0);
        tick();
        chk("add_wb_state", {29'd0, state}, 32'd4);
        chk("add_wb_ctl", {29'd0, reg_write, reg_dst, instr_done}, 32'b111);
        tick();
        chk("add_done_state", {29'd0, state}, 32'd0);
        chk("add_done_regw", {31'd0, reg_write}, 32'd0);
        chk("add_cnt", instr_cnt, 32'd1);

        // Other R-type functs: alu_ctrl in EX
        for (int i = 0; i < 4; i++) begin
            funct = fn_tab[i];
            tick(); tick();
            chk("rtype_alu", {29'd0, alu_ctrl}, {29'd0, alu_tab[i]});
            tick(); tick();
        end
        chk("rtype_cnt", instr_cnt, 32'd5);

        // LW
        opcode = 6'h23;
        tick(); tick();
        chk("lw_ex", {29'd0, alu_src_a, alu_src_b}, 32'b110);
        tick();
        chk("lw_mem", {28'd0, state, 1'b0} | {31'd0, 1'b0}, 32'd6);
        chk("lw_mem_rd", {30'd0, mem_read, iord}, 32'b11);
        tick();
        chk("lw_wb", {28'd0, reg_write, mem_to_reg, reg_dst, instr_done}, 32'b1101);
        tick();
        chk("lw_cnt", {instr_cnt[28:0], state}, {29'd6, 3'd0});

        // SW
        opcode = 6'h2B;
        tick(); tick();
        chk("sw_ex_wr", {31'd0, mem_write}, 32'd0);
        tick();
        chk("sw_mem", {27'd0, state, mem_write, instr_done}, {27'd0, 3'd3, 2'b11});
        tick();
        chk("sw_cnt", {instr_cnt[28:0], state, mem_write}, {28'd7, 4'd0});

        // BEQ taken
        opcode = 6'h04; zero = 1'b1;
        tick(); tick();
        chk("beq1_ex", {25'd0, pc_en, pc_src, alu_ctrl, instr_done}, {25'd0, 1'b1, 2'd1, 3'b110, 1'b1});
        tick();
        chk("beq1_cnt", {instr_cnt[28:0], state}, {29'd8, 3'd0});

        // BEQ not taken
        zero = 1'b0;
        tick(); tick();
        chk("beq0_ex", {30'd0, pc_en, instr_done}, 32'b01);
        tick();
        chk("beq0_cnt", {instr_cnt[28:0], state}, {29'd9, 3'd0});

        // J
        opcode = 6'h02;
        tick();
        chk("j_id", {28'd0, pc_en, pc_src, instr_done}, 32'b1101);
        tick();
        chk("j_cnt", {instr_cnt[28:0], state}, {29'd10, 3'd0});

        // Illegal opcode, skip
        opcode = 6'h3F;
        tick();
        chk("ill_id", {27'd0, state, illegal, instr_done}, {27'd0, 3'd1, 2'b10});
        tick();
        chk("ill_back", {instr_cnt[27:0], state, illegal}, {28'd10, 4'd0});

        // Illegal funct on R-type
        opcode = 6'h00; funct = 6'h21;
        tick();
        chk("illfn_id", {31'd0, illegal}, 32'd1);
        tick();
        chk("illfn_back", {instr_cnt[28:0], state}, {29'd10, 3'd0});

        // Reset during MEM of LW
        opcode = 6'h23; funct = 6'h20;
        tick(); tick(); tick();
        chk("lwr_mem", {28'd0, state, mem_read}, {28'd0, 3'd3, 1'b1});
        reset = 1'b1;
        #1;
        chk("lwr_drop", {31'd0, mem_read}, 32'd0);
        tick();
        chk("lwr_state", {29'd0, state}, 32'd0);
        chk("lwr_cnt", instr_cnt, 32'd0);
        reset = 1'b0;

        // Trap variant
        reset1 = 1'b0;
        tick();
        chk("trap_id", {28'd0, state1, illegal1}, {28'd0, 3'd1, 1'b1});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("trap_halt", {25'd0, state1, halted1, pc_en1, mem_read1, mem_write1},
                {25'd0, 3'd5, 1'b1, 3'b000});
            chk("trap_en", {29'd0, ir_write1, reg_write1, instr_done1}, 32'd0);
        end
        reset1 = 1'b1;
        tick();
        chk("trap_rst", {28'd0, state1, halted1}, 32'd0);
        chk("trap_cnt", instr_cnt1, 32'd0);

        // Counter wrap with 16 back-to-back J
        reset2 = 1'b0;
        repeat (30) tick();
        chk("wrap_15", {28'd0, instr_cnt2}, 32'd15);
        tick();
        chk("wrap_j16", {31'd0, instr_done2}, 32'd1);
        tick();
        chk("wrap_0", {25'd0, instr_cnt2, state2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM of the multicycle MIPS-subset CPU.
- Sequences the PC, instruction register, memory, register file and ALU through the IF/ID/EX/MEM/WB steps.
- Decodes opcode/funct from the IR output.
- Counts retired instructions and traps illegal encodings.

Parameters:
CNT_W, 32, width of the retired-instruction counter.
ILLEGAL_TRAP, 0, 0: an illegal instruction is skipped and the FSM returns to IF; 1: the FSM enters HALT until reset.

Ports:
clk  input  1  system clock; state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
opcode  input  6  instr[31:26] from the IR output.
funct  input  6  instr[5:0] from the IR output.
zero  input  1  ALU zero flag.
pc_en  output  1  PC write enable.
pc_src  output  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
ir_write  output  1  IR load enable.
reg_write  output  1  register file write enable.
reg_dst  output  1  destination select: 0 = rt, 1 = rd.
mem_to_reg  output  1  write-back select: 0 = ALUOut, 1 = MDR.
alu_src_a  output  1  0 = PC, 1 = register A.
alu_src_b  output  2  0 = register B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
instr_done  output  1  one-cycle pulse in the last state of each retired instruction.
illegal  output  1  one-cycle pulse in ID when the encoding is illegal.
halted  output  1  high while in HALT.
state  output  3  current state, for debug.
instr_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- States and encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Registered state; all other outputs are combinational from state, opcode, funct and zero.
- Reset:
  - While reset is high, every enable/strobe output is forced to 0.
  - At the first rising edge with reset high: state=IF, instr_cnt=0, halted=0.
  - Reset asserted mid-instruction abandons it; it is not counted.
- Default values in every state: all enables 0, alu_ctrl=add, all selects 0.
- IR timing:
  - ir_write is asserted in IF; the IR captures on the falling edge inside IF.
  - opcode/funct are valid from ID onward and are never used in IF.
- IF: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=1, add, pc_src=0, pc_en=1. Next state: ID.
- ID:
  - alu_src_a=0, alu_src_b=3, add (branch target goes to ALUOut).
  - J (0x02): pc_src=2, pc_en=1, instr_done=1; next IF.
  - Illegal: illegal=1; next HALT if ILLEGAL_TRAP, else IF. instr_cnt is not incremented.
  - Otherwise next EX.
- EX:
  - R-type: alu_src_a=1, alu_src_b=0, alu_ctrl from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt); next WB.
  - LW (0x23) / SW (0x2B) / ADDI (0x08): alu_src_a=1, alu_src_b=2, add; next MEM for LW/SW, WB for ADDI.
  - BEQ (0x04): alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_en=zero, instr_done=1; next IF.
- MEM:
  - iord=1.
  - LW: mem_read=1; next WB.
  - SW: mem_write=1, instr_done=1; next IF.
- WB:
  - reg_write=1, instr_done=1; next IF.
  - R-type: reg_dst=1, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
  - ADDI: reg_dst=0, mem_to_reg=0.
- HALT: all enables 0, halted=1; stays in HALT until reset.
- Illegal means any opcode not listed above, or R-type with an unlisted funct.
- Latencies in cycles: J 2, BEQ 3, R-type/ADDI/SW 4, LW 5, illegal 2.
- instr_cnt increments on the rising edge ending any cycle with instr_done=1. It wraps modulo 2^CNT_W with no saturation.
- BEQ with zero=0 still counts as retired.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - alu_ctrl codes;
  - pc_src and alu_src_b select codes.
- One sub-module, alu_decoder: input funct, outputs alu_ctrl and funct_illegal. It is purely combinational and instantiated once.

Test Plan:
- Reset held 3 cycles, then R-type add (opcode 0x00, funct 0x20) -> states 0,1,2,4, then 0. reg_write=1 and reg_dst=1 in cycle 4 only; instr_cnt=1.
- LW (0x23) -> 5 cycles. mem_read=1 with iord=1 in MEM; mem_to_reg=1 and reg_write=1 in WB. SW (0x2B) -> 4 cycles, mem_write=1 only in MEM.
- BEQ (0x04) with zero=1 -> pc_en=1, pc_src=1 in EX. With zero=0 -> pc_en=0 in EX. Both return to IF after 3 cycles and increment instr_cnt.
- J (0x02) -> pc_en=1, pc_src=2 in ID; 2-cycle instruction.
- Opcode 0x3F with ILLEGAL_TRAP=0 -> illegal pulse in ID, back to IF, instr_cnt unchanged. With ILLEGAL_TRAP=1 -> halted=1 and all enables 0 for 10 cycles; reset returns the FSM to IF.
- CNT_W=4, 16 back-to-back J -> instr_cnt wraps to 0. Reset asserted during MEM of an LW -> mem_read drops the same cycle, state=IF on the next edge, instr_cnt=0.
